pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Hazard and sequencing controller for the five-stage LEGv8 pipeline (fetch, iDecode, iExecute, iMemory, iWrite_back). It performs four jobs:
- detects load-use hazards and inserts one bubble;
- flushes the three younger stages when a branch resolves taken in the memory stage;
- suppresses architectural writes until the pipeline has filled after reset;
- provides run/halt/single-step debug control.

It owns every stall, flush and enable signal in the datapath, and keeps saturating stall and flush counters.

## Interface
Parameters:
- FILL_CYCLES, 4, cycles after reset during which register and memory writes are suppressed.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  pipeline clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low; sampled on the rising edge of clk.
- run  in  1  1 = free-run; 0 = halt the pipeline.
- step  in  1  single-cycle pulse; advances one cycle while halted.
- rn_id  in  5  first source register of the instruction in decode.
- rm_id  in  5  second source register of the instruction in decode.
- uses_rm_id  in  1  the decode instruction reads rm.
- mem_read_ie  in  1  the execute-stage instruction is a load.
- write_register_ie  in  5  destination register of the execute-stage instruction.
- pc_src  in  1  branch taken, resolved in the memory stage.
- pipe_en  out  1  global enable for the PC and all pipeline registers.
- pc_write  out  1  PC update enable.
- ifid_write  out  1  IF/ID register update enable.
- idex_bubble  out  1  load all-zero control into ID/EX.
- flush  out  1  zero the control fields of IF/ID, ID/EX and EX/MEM.
- wr_allow  out  1  gates reg_write and mem_write.
- stall_count  out  CNT_W  load-use stalls, saturating.
- flush_count  out  CNT_W  taken-branch flushes, saturating.
- state  out  2  current FSM state, for debug.

## Operation
- FSM states: FILL=0, RUN=1, HALT=2, STEP=3.
- Hazard term: haz = mem_read_ie & (write_register_ie != 31) & ((write_register_ie == rn_id) | (uses_rm_id & write_register_ie == rm_id)). X31 (XZR) never causes a hazard.
- Qualification: haz and pc_src act only when pipe_en=1.
- Flush: pc_src → flush=1 this cycle. Flush overrides haz: no bubble is inserted and no stall is counted. pc_write stays 1 so the branch target loads.
- Stall: haz & !pc_src → pc_write=0, ifid_write=0, idex_bubble=1 for exactly one cycle. In the next cycle the load has moved to memory and haz clears naturally.
- FILL:
  - Fill counter counts up from 0 with pipe_en=1 and wr_allow=0.
  - At FILL_CYCLES-1 → RUN if run=1, else → HALT.
  - Hazard and flush logic are active during FILL; counters do not increment.
- RUN: pipe_en=1, wr_allow=1. run=0 → HALT at the next edge.
- HALT: pipe_en=0, pc_write=0, ifid_write=0, idex_bubble=0, flush=0, wr_allow=0. Then, in priority order:
  - run=1 → RUN;
  - step=1 → STEP.
- STEP: one cycle identical to RUN, including hazard, flush and counting. Next state: RUN if run=1, else HALT.
- Counters:
  - stall_count increments on each qualified stall cycle in RUN or STEP.
  - flush_count increments on each qualified pc_src cycle in RUN or STEP.
  - Both saturate at all-ones.
- Outputs are Mealy: combinational from state and current inputs. Counters and state are registered.

## Timing
- Reset (reset=0 at an edge), next cycle: state=FILL, fill counter=0, both counters=0. Outputs are then pipe_en=1, pc_write=1, ifid_write=1, idex_bubble=0, flush=0, wr_allow=0.
- Reset mid-operation: aborts any state, including HALT or STEP, and discards a pending step.
- Stall and flush responses have zero-cycle latency: same cycle as the causing inputs.
- Counter values are visible one cycle after the event.
- First wr_allow=1: cycle FILL_CYCLES after reset deassertion, provided run=1.
- step is edge-free. It is level-sampled only in HALT; a step held high produces one STEP per two cycles (HALT, STEP, HALT, ...).
- pc_src and haz arriving together while in HALT are ignored.
- Simultaneous run=1 and step=1 in HALT → RUN.

## Structure
- Shared package or definitions header holds:
  - state encodings FILL/RUN/HALT/STEP;
  - XZR register number (31);
  - the default FILL_CYCLES value.
- One natural sub-module: sat_counter, parameterized by width with inc/clear inputs, instantiated twice.
- Hazard compare is inline combinational logic. No other sub-modules.

## Test plan
- Reset, then run=1 with no hazards → wr_allow=0 for cycles 0–3 and 1 from cycle 4; state FILL→RUN; counters stay 0.
- In RUN, mem_read_ie=1, write_register_ie=5, rn_id=5 for one cycle → pc_write=0, ifid_write=0, idex_bubble=1 that cycle only; stall_count=1 one cycle later. Repeat with write_register_ie=31 → no stall.
- In RUN, pc_src=1 together with a hazard on rm_id=9 (uses_rm_id=1) → flush=1, idex_bubble=0, pc_write=1; flush_count=1; stall_count unchanged.
- In RUN, drop run to 0 → next cycle HALT with pipe_en=0. Pulse step while a hazard is present → exactly one STEP cycle with stall outputs asserted and stall_count+1, then HALT.
- Preload stall_count near saturation (CNT_W=4 variant) and force 20 stalls → counter holds at 15.
- Assert reset=0 during STEP → next cycle state=FILL, counters=0, wr_allow=0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the LEGv8 pipeline hazard and sequencing controller:
// FSM state encodings, the zero-register number and default fill depth.
package pipeline_hazard_ctrl_pkg;

  // FSM state encodings kept as plain constants so legacy code can compare
  // against the two-bit debug state output directly.
  localparam logic [1:0] ST_FILL = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;
  localparam logic [1:0] ST_STEP = 2'd3;

  // X31 reads as zero and is never a real producer, so it cannot cause a hazard.
  localparam logic [4:0] XZR = 5'd31;

  // Number of cycles after reset during which architectural writes are blocked.
  localparam int DEFAULT_FILL_CYCLES = 4;

  // Bundle of every datapath control produced by the controller.
  typedef struct packed {
    logic pipe_en;
    logic pc_write;
    logic ifid_write;
    logic idex_bubble;
    logic flush;
    logic wr_allow;
  } ctrl_t;

  // The pipeline advances in every state except HALT.
  function automatic logic state_advances(input logic [1:0] st);
    return st != ST_HALT;
  endfunction

  // Performance counters and architectural writes are live only in RUN and STEP.
  function automatic logic state_commits(input logic [1:0] st);
    return (st == ST_RUN) || (st == ST_STEP);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones once reached.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_r;

  // Clear has priority; otherwise count up on inc until all-ones, then hold.
  always_ff @(posedge clk) begin
    if (clear) begin
      count_r <= '0;
    end else if (inc && (count_r != {WIDTH{1'b1}})) begin
      count_r <= count_r + WIDTH'(1);
    end
  end

  assign count = count_r;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the five-stage LEGv8 pipeline.
// Inserts one bubble on load-use hazards, flushes the younger stages on a
// taken branch, blocks architectural writes while the pipeline fills after
// reset, and provides run/halt/single-step debug control.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int FILL_CYCLES = DEFAULT_FILL_CYCLES,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             step,
  input  logic [4:0]       rn_id,
  input  logic [4:0]       rm_id,
  input  logic             uses_rm_id,
  input  logic             mem_read_ie,
  input  logic [4:0]       write_register_ie,
  input  logic             pc_src,
  output logic             pipe_en,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_bubble,
  output logic             flush,
  output logic             wr_allow,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic [1:0]       state
);

  localparam int FILL_W = (FILL_CYCLES > 2) ? $clog2(FILL_CYCLES) : 1;
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(FILL_CYCLES - 1);

  logic [1:0]        state_r;
  logic [1:0]        state_nxt;
  logic [FILL_W-1:0] fill_cnt;
  logic              fill_last;
  logic              advancing;
  logic              committing;
  logic              haz;
  logic              haz_q;
  logic              branch_q;
  logic              stall;
  logic              stall_inc;
  logic              flush_inc;
  ctrl_t             ctrl;

  assign advancing  = state_advances(state_r);
  assign committing = state_commits(state_r);
  assign fill_last  = (fill_cnt == FILL_LAST);

  // Load-use hazard: the load in execute writes a register the decode
  // instruction reads; the zero register is excluded as a producer.
  always_comb begin
    haz = mem_read_ie
        && (write_register_ie != XZR)
        && ((write_register_ie == rn_id)
            || (uses_rm_id && (write_register_ie == rm_id)));
  end

  // Qualify hazards with the pipeline enable; a taken branch wins over a stall
  // because the stalled instruction is about to be flushed anyway.
  always_comb begin
    haz_q     = haz && advancing;
    branch_q  = pc_src && advancing;
    stall     = haz_q && !branch_q;
    stall_inc = stall && committing;
    flush_inc = branch_q && committing;
  end

  // Mealy control outputs derived from the current state and hazard terms.
  always_comb begin
    ctrl             = '0;
    ctrl.pipe_en     = advancing;
    ctrl.pc_write    = advancing && !stall;
    ctrl.ifid_write  = advancing && !stall;
    ctrl.idex_bubble = stall;
    ctrl.flush       = branch_q;
    ctrl.wr_allow    = committing;
  end

  assign pipe_en     = ctrl.pipe_en;
  assign pc_write    = ctrl.pc_write;
  assign ifid_write  = ctrl.ifid_write;
  assign idex_bubble = ctrl.idex_bubble;
  assign flush       = ctrl.flush;
  assign wr_allow    = ctrl.wr_allow;

  // Next-state selection; in HALT a run request beats a step request.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      ST_FILL: begin
        if (fill_last) begin
          state_nxt = run ? ST_RUN : ST_HALT;
        end
      end
      ST_RUN: begin
        state_nxt = run ? ST_RUN : ST_HALT;
      end
      ST_HALT: begin
        if (run) begin
          state_nxt = ST_RUN;
        end else if (step) begin
          state_nxt = ST_STEP;
        end
      end
      ST_STEP: begin
        state_nxt = run ? ST_RUN : ST_HALT;
      end
      default: begin
        state_nxt = ST_FILL;
      end
    endcase
  end

  // State register; reset always returns to FILL, discarding any pending step.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= ST_FILL;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Fill counter advances only while filling and rests at zero elsewhere.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fill_cnt <= '0;
    end else if ((state_r == ST_FILL) && !fill_last) begin
      fill_cnt <= fill_cnt + FILL_W'(1);
    end else begin
      fill_cnt <= '0;
    end
  end

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_stall_counter (
    .clk   (clk),
    .clear (!reset),
    .inc   (stall_inc),
    .count (stall_count)
  );

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_flush_counter (
    .clk   (clk),
    .clear (!reset),
    .inc   (flush_inc),
    .count (flush_count)
  );

  assign state = state_r;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: a table of per-cycle vectors
// from reset through fill, stalls, flushes and halt/step, followed by
// hand-written sequences for reset during STEP and counter saturation.
module tb_pipeline_hazard_ctrl;

  logic        clk;
  logic        reset;
  logic        run;
  logic        step;
  logic [4:0]  rn_id;
  logic [4:0]  rm_id;
  logic        uses_rm_id;
  logic        mem_read_ie;
  logic [4:0]  write_register_ie;
  logic        pc_src;

  logic        pipe_en, pc_write, ifid_write, idex_bubble, flush, wr_allow;
  logic [15:0] stall_count, flush_count;
  logic [1:0]  state;

  logic        s_pipe_en, s_pc_write, s_ifid_write, s_idex_bubble, s_flush, s_wr_allow;
  logic [3:0]  s_stall_count, s_flush_count;
  logic [1:0]  s_state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       run;
    logic       step;
    logic [4:0] rn;
    logic [4:0] rm;
    logic       uses_rm;
    logic       mem_read;
    logic [4:0] wr_reg;
    logic       pc_src;
    logic [5:0] outs;
    logic [1:0] st;
    int         sc;
    int         fc;
  } vec_t;

  vec_t vecs[26];

  pipeline_hazard_ctrl #(
    .FILL_CYCLES (4),
    .CNT_W       (16)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .run               (run),
    .step              (step),
    .rn_id             (rn_id),
    .rm_id             (rm_id),
    .uses_rm_id        (uses_rm_id),
    .mem_read_ie       (mem_read_ie),
    .write_register_ie (write_register_ie),
    .pc_src            (pc_src),
    .pipe_en           (pipe_en),
    .pc_write          (pc_write),
    .ifid_write        (ifid_write),
    .idex_bubble       (idex_bubble),
    .flush             (flush),
    .wr_allow          (wr_allow),
    .stall_count       (stall_count),
    .flush_count       (flush_count),
    .state             (state)
  );

  pipeline_hazard_ctrl #(
    .FILL_CYCLES (4),
    .CNT_W       (4)
  ) dut_small (
    .clk               (clk),
    .reset             (reset),
    .run               (run),
    .step              (step),
    .rn_id             (rn_id),
    .rm_id             (rm_id),
    .uses_rm_id        (uses_rm_id),
    .mem_read_ie       (mem_read_ie),
    .write_register_ie (write_register_ie),
    .pc_src            (pc_src),
    .pipe_en           (s_pipe_en),
    .pc_write          (s_pc_write),
    .ifid_write        (s_ifid_write),
    .idex_bubble       (s_idex_bubble),
    .flush             (s_flush),
    .wr_allow          (s_wr_allow),
    .stall_count       (s_stall_count),
    .flush_count       (s_flush_count),
    .state             (s_state)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic s, input logic [4:0] rn,
                              input logic [4:0] rm, input logic u, input logic mr,
                              input logic [4:0] wr, input logic pc, input logic [5:0] outs,
                              input logic [1:0] st, input int sc, input int fc);
    vec_t v;
    v.run = r; v.step = s; v.rn = rn; v.rm = rm; v.uses_rm = u;
    v.mem_read = mr; v.wr_reg = wr; v.pc_src = pc;
    v.outs = outs; v.st = st; v.sc = sc; v.fc = fc;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic r, input logic s, input logic [4:0] rn,
                                input logic [4:0] rm, input logic u, input logic mr,
                                input logic [4:0] wr, input logic pc);
    run = r; step = s; rn_id = rn; rm_id = rm; uses_rm_id = u;
    mem_read_ie = mr; write_register_ie = wr; pc_src = pc;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Outputs packed as {pipe_en, pc_write, ifid_write, idex_bubble, flush, wr_allow}.
  initial begin
    logic [5:0] o_run, o_fill, o_halt, o_stall_run, o_stall_fill, o_flush_run, o_flush_fill;
    o_run        = 6'b111001;
    o_fill       = 6'b111000;
    o_halt       = 6'b000000;
    o_stall_run  = 6'b100101;
    o_stall_fill = 6'b100100;
    o_flush_run  = 6'b111011;
    o_flush_fill = 6'b111010;

    vecs[0]  = mk(1, 0,  0,  0, 0, 0,  0, 0, o_fill,       2'd0, 0, 0);
    vecs[1]  = mk(1, 0,  5,  0, 0, 1,  5, 0, o_stall_fill, 2'd0, 0, 0);
    vecs[2]  = mk(1, 0,  0,  0, 0, 0,  0, 1, o_flush_fill, 2'd0, 0, 0);
    vecs[3]  = mk(1, 0,  0,  0, 0, 0,  0, 0, o_fill,       2'd0, 0, 0);
    vecs[4]  = mk(1, 0,  0,  0, 0, 0,  0, 0, o_run,        2'd1, 0, 0);
    vecs[5]  = mk(1, 0,  5,  0, 0, 1,  5, 0, o_stall_run,  2'd1, 0, 0);
    vecs[6]  = mk(1, 0,  0,  0, 0, 0,  0, 0, o_run,        2'd1, 1, 0);
    vecs[7]  = mk(1, 0, 31, 31, 1, 1, 31, 0, o_run,        2'd1, 1, 0);
    vecs[8]  = mk(1, 0,  1,  9, 0, 1,  9, 0, o_run,        2'd1, 1, 0);
    vecs[9]  = mk(1, 0,  1,  9, 1, 1,  9, 1, o_flush_run,  2'd1, 1, 0);
    vecs[10] = mk(1, 0,  1,  9, 1, 1,  9, 0, o_stall_run,  2'd1, 1, 1);
    vecs[11] = mk(1, 0,  0,  0, 0, 0,  0, 0, o_run,        2'd1, 2, 1);
    vecs[12] = mk(1, 0,  5,  0, 0, 0,  5, 0, o_run,        2'd1, 2, 1);
    vecs[13] = mk(0, 0,  0,  0, 0, 0,  0, 0, o_run,        2'd1, 2, 1);
    vecs[14] = mk(0, 0,  5,  0, 0, 1,  5, 1, o_halt,       2'd2, 2, 1);
    vecs[15] = mk(0, 1,  5,  0, 0, 1,  5, 0, o_halt,       2'd2, 2, 1);
    vecs[16] = mk(0, 0,  5,  0, 0, 1,  5, 0, o_stall_run,  2'd3, 2, 1);
    vecs[17] = mk(0, 0,  0,  0, 0, 0,  0, 0, o_halt,       2'd2, 3, 1);
    vecs[18] = mk(0, 1,  0,  0, 0, 0,  0, 0, o_halt,       2'd2, 3, 1);
    vecs[19] = mk(0, 1,  0,  0, 0, 0,  0, 0, o_run,        2'd3, 3, 1);
    vecs[20] = mk(0, 1,  0,  0, 0, 0,  0, 0, o_halt,       2'd2, 3, 1);
    vecs[21] = mk(1, 1,  0,  0, 0, 0,  0, 1, o_flush_run,  2'd3, 3, 1);
    vecs[22] = mk(1, 0,  0,  0, 0, 0,  0, 0, o_run,        2'd1, 3, 2);
    vecs[23] = mk(0, 0,  0,  0, 0, 0,  0, 0, o_run,        2'd1, 3, 2);
    vecs[24] = mk(1, 1,  0,  0, 0, 0,  0, 0, o_halt,       2'd2, 3, 2);
    vecs[25] = mk(1, 0,  0,  0, 0, 0,  0, 0, o_run,        2'd1, 3, 2);

    // Reset with quiet inputs, then release so cycle 0 of FILL begins.
    reset = 1'b0;
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // Table-driven phase: one vector per cycle, checked mid-cycle.
    for (int i = 0; i < 26; i++) begin
      apply_stimulus(vecs[i].run, vecs[i].step, vecs[i].rn, vecs[i].rm,
                     vecs[i].uses_rm, vecs[i].mem_read, vecs[i].wr_reg, vecs[i].pc_src);
      @(negedge clk);
      check_output($sformatf("vec%0d outs", i),
                   {26'd0, pipe_en, pc_write, ifid_write, idex_bubble, flush, wr_allow},
                   {26'd0, vecs[i].outs});
      check_output($sformatf("vec%0d state", i), {30'd0, state}, {30'd0, vecs[i].st});
      check_output($sformatf("vec%0d stall_count", i), {16'd0, stall_count}, vecs[i].sc);
      check_output($sformatf("vec%0d flush_count", i), {16'd0, flush_count}, vecs[i].fc);
      next_cycle();
    end

    // Reset asserted during STEP: drop run, step once, reset inside STEP.
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
    next_cycle();
    apply_stimulus(0, 1, 0, 0, 0, 0, 0, 0);
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    check_output("step_before_reset state", {30'd0, state}, 32'd3);
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    check_output("after_reset state", {30'd0, state}, 32'd0);
    check_output("after_reset stall_count", {16'd0, stall_count}, 32'd0);
    check_output("after_reset flush_count", {16'd0, flush_count}, 32'd0);
    check_output("after_reset wr_allow", {31'd0, wr_allow}, 32'd0);
    check_output("after_reset pipe_en", {31'd0, pipe_en}, 32'd1);

    // With run low and step held, FILL must ignore step and end in HALT.
    repeat (4) next_cycle();
    @(negedge clk);
    check_output("fill_to_halt state", {30'd0, state}, 32'd2);
    check_output("fill_to_halt pipe_en", {31'd0, pipe_en}, 32'd0);

    // Saturation: fresh reset, fill with run high, then 20 back-to-back stalls.
    next_cycle();
    reset = 1'b0;
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0);
    next_cycle();
    reset = 1'b1;
    repeat (4) next_cycle();
    apply_stimulus(1, 0, 7, 0, 0, 1, 7, 0);
    repeat (10) next_cycle();
    @(negedge clk);
    check_output("sat after 10 small", {28'd0, s_stall_count}, 32'd10);
    check_output("sat stall outputs", {31'd0, s_idex_bubble}, 32'd1);
    next_cycle();
    repeat (9) next_cycle();
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check_output("sat after 20 small", {28'd0, s_stall_count}, 32'd15);
    check_output("sat after 20 wide", {16'd0, stall_count}, 32'd20);
    check_output("sat flush small", {28'd0, s_flush_count}, 32'd0);
    next_cycle();
    @(negedge clk);
    check_output("sat hold small", {28'd0, s_stall_count}, 32'd15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
